// File: rtl/char_id_pkg.sv
// Shared constants and types for the streaming character-ID encoder.
package char_id_pkg;

  typedef enum logic [1:0] {
    KIND_GLYPH     = 2'd0,
    KIND_NEWLINE   = 2'd1,
    KIND_BACKSPACE = 2'd2,
    KIND_INVALID   = 2'd3
  } kind_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  localparam logic [8:0] DIG_LO = 9'd48;
  localparam logic [8:0] DIG_HI = 9'd57;
  localparam logic [8:0] UP_LO  = 9'd65;
  localparam logic [8:0] UP_HI  = 9'd90;
  localparam logic [8:0] LO_LO  = 9'd97;
  localparam logic [8:0] LO_HI  = 9'd122;
  localparam logic [8:0] GLYPH_EXT_OFS = 9'd62;

  // use_num selects the computed id9; otherwise the entry carries INVALID_ID.
  typedef struct packed {
    logic       push;
    logic       err;
    logic       use_num;
    kind_e      kind;
    logic [8:0] id9;
  } enc_t;

endpackage

// File: rtl/char_id_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit to split full from empty.
module char_id_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wptr, rptr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + 1'b1;
      if (rd_en && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing reads it until a write has landed.
  always_ff @(posedge clock) begin
    if (wr_en && !full) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/char_id_stream_encoder.sv
// Byte stream to glyph-ID/kind encoder with output FIFO and saturating error counter.
module char_id_stream_encoder
  import char_id_pkg::*;
#(
  parameter int ID_W       = 8,
  parameter int EXT_BASE   = 128,
  parameter int EXT_LAST   = 195,
  parameter int INVALID_ID = 255,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             case_fold,
  output logic [ID_W-1:0]  out_id,
  output logic [1:0]       out_kind,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ERR_W-1:0] err_count,
  input  logic             err_clr
);
  localparam int EW = ID_W + 2;
  localparam logic [ID_W-1:0] INV = ID_W'(INVALID_ID);

  if (INVALID_ID <= 62 + EXT_LAST - EXT_BASE) begin : g_bad_invalid_id
    $error("INVALID_ID collides with the glyph ID range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic enc_t encode(input logic [7:0] b, input logic cf);
    enc_t       e;
    logic [8:0] v;
    v         = {1'b0, b};
    e.push    = 1'b1;
    e.err     = 1'b0;
    e.use_num = 1'b1;
    e.kind    = KIND_GLYPH;
    e.id9     = '0;
    if (v >= DIG_LO && v <= DIG_HI)      e.id9 = v - 9'd48;
    else if (v >= UP_LO && v <= UP_HI)   e.id9 = v - 9'd55;
    else if (v >= LO_LO && v <= LO_HI)   e.id9 = cf ? v - 9'd87 : v - 9'd61;
    else if (v >= 9'(EXT_BASE) && v <= 9'(EXT_LAST))
      e.id9 = v - 9'(EXT_BASE) + GLYPH_EXT_OFS;
    else begin
      e.use_num = 1'b0;
      if (b == ASCII_SP)      e.kind = KIND_GLYPH;
      else if (b == ASCII_LF) e.kind = KIND_NEWLINE;
      else if (b == ASCII_BS) e.kind = KIND_BACKSPACE;
      else if (b == ASCII_CR) e.push = 1'b0;
      else begin
        e.kind = KIND_INVALID;
        e.err  = 1'b1;
      end
    end
    return e;
  endfunction

  enc_t          enc;
  logic          accept, rd_en, full, empty;
  logic [EW-1:0] wr_data, rd_data, last;

  always_comb begin
    enc     = encode(in_data, case_fold);
    wr_data = {enc.kind, enc.use_num ? ID_W'(enc.id9) : INV};
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  char_id_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (accept && enc.push),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // Last popped entry, presented while the FIFO is empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   last <= {KIND_INVALID, INV};
    else if (rd_en) last <= rd_data;
  end

  assign {out_kind, out_id} = empty ? last : rd_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      err_count <= '0;
    else if (err_clr)  err_count <= '0;
    else if (accept && enc.err && err_count != '1)
      err_count <= err_count + ERR_W'(1);
  end

endmodule
